// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the clock-divider controller.
// Contents: controller state enum, default divide-ratio field width.
// Imported by clkdiv_ctrl and clkdiv_cnt.
package clkdiv_pkg;

   localparam int DIV_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PEND  = 2'd2,   // new ratio held, waiting for the current period to end
      ST_DRAIN = 2'd3    // en dropped, finishing the current period
   } state_t;

endpackage

// File: rtl/clkdiv_cnt.sv
// Period counter: produces registered cnt, clkout and tick for ratio n.
// Ports: run/restart/n describe the *next* cycle; cnt/clkout/tick are flops,
//        tick_nx is the value tick takes at the next edge.
// clkout/tick are computed from the next counter value, so they line up with cnt.
module clkdiv_cnt #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,       // controller will be running next cycle
   input  logic             restart,   // next cycle starts a new period (cnt = 0)
   input  logic [DIV_W-1:0] n,         // ratio applied next cycle
   output logic [DIV_W-1:0] cnt,
   output logic             clkout,
   output logic             tick,
   output logic             tick_nx
);

   logic [DIV_W-1:0] cnt_nx;
   logic [DIV_W:0]   half;       // ceil(n/2), one bit wider to avoid overflow
   logic             clkout_nx;

   always_comb begin
      half      = ({1'b0, n} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
      cnt_nx    = (!run || restart) ? '0 : cnt + 1'b1;
      clkout_nx = run && ({1'b0, cnt_nx} < half);
      tick_nx   = run && (cnt_nx == n - 1'b1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         clkout <= 1'b0;
         tick   <= 1'b0;
      end else begin
         cnt    <= cnt_nx;
         clkout <= clkout_nx;
         tick   <= tick_nx;
      end
   end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Clock-divider controller: divides clk by a ratio changed via valid/ready,
// never emitting a partial period; en starts/stops on period boundaries.
// Ports: en, cfg_valid/cfg_div/cfg_ready, clkout, tick, running, div_cur.
// Option CLKDIV_CTRL_PERIOD_CNT_EN adds a 16-bit period_cnt output counting ticks.
module clkdiv_ctrl
   import clkdiv_pkg::*;
#(
   parameter int DIV_W   = DIV_W_DEF,
   parameter int DIV_RST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             clkout,
   output logic             tick,
   output logic             running,
   output logic [DIV_W-1:0] div_cur
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
   ,
   output logic [15:0]      period_cnt
`endif
);

   localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);

   state_t           state, state_nx;
   logic [DIV_W-1:0] div_pend, div_pend_nx, div_cur_nx;
   logic [DIV_W-1:0] cfg_eff;
   logic [DIV_W-1:0] cnt;
   logic             xfer;
   logic             run_nx;
   logic             restart;
   logic             tick_nx;

   assign running   = (state != ST_IDLE);
   assign cfg_ready = (state == ST_IDLE) || (state == ST_RUN);
   assign xfer      = cfg_valid && cfg_ready;
   // A zero ratio is meaningless; treat it as divide-by-1.
   assign cfg_eff   = (cfg_div == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : cfg_div;

   // The registered tick marks the last cycle of the current period, which is
   // the only point where ratio changes and stop requests take effect.
   always_comb begin
      state_nx    = state;
      div_cur_nx  = div_cur;
      div_pend_nx = div_pend;
      case (state)
         ST_IDLE: begin
            if (xfer) div_cur_nx = cfg_eff;
            if (en)   state_nx   = ST_RUN;
         end
         ST_RUN: begin
            if (xfer) begin
               div_pend_nx = cfg_eff;
               state_nx    = ST_PEND;
            end else if (!en) begin
               state_nx = tick ? ST_IDLE : ST_DRAIN;
            end
         end
         ST_PEND: begin
            if (tick) begin
               div_cur_nx = div_pend;
               state_nx   = en ? ST_RUN : ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (en)        state_nx = ST_RUN;
            else if (tick) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
      run_nx  = (state_nx != ST_IDLE);
      restart = tick || (state == ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         div_cur  <= DIV_RST_V;
         div_pend <= DIV_RST_V;
      end else begin
         state    <= state_nx;
         div_cur  <= div_cur_nx;
         div_pend <= div_pend_nx;
      end
   end

   clkdiv_cnt #(.DIV_W(DIV_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .run     (run_nx),
      .restart (restart),
      .n       (div_cur_nx),
      .cnt     (cnt),
      .clkout  (clkout),
      .tick    (tick),
      .tick_nx (tick_nx)
   );

`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
   // Counts in step with the registered tick, so the value is already
   // incremented during the cycle the tick is visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         period_cnt <= '0;
      else if (state == ST_IDLE && state_nx == ST_RUN)
         period_cnt <= {15'd0, tick_nx};
      else if (tick_nx)
         period_cnt <= period_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl: cycle table plus hand-written reset sequence.
module tb_clkdiv_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [7:0] cfg_div = 8'd0;
   logic       cfg_ready, clkout, tick, running;
   logic [7:0] div_cur;
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
   logic [15:0] period_cnt;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   clkdiv_ctrl #(.DIV_W(8), .DIV_RST(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .clkout    (clkout),
      .tick      (tick),
      .running   (running),
      .div_cur   (div_cur)
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
      ,
      .period_cnt(period_cnt)
`endif
   );

   // One row = inputs applied before an edge, outputs expected after it.
   typedef struct {
      logic       en;
      logic       cv;
      logic [7:0] cd;
      logic [3:0] exp_flags;  // {clkout, tick, running, cfg_ready}
      logic [7:0] exp_div;
   } vec_t;

   vec_t vecs[$];

   task automatic v(input logic e, input logic c, input logic [7:0] d,
                    input logic ck, input logic tk, input logic rn,
                    input logic rd, input logic [7:0] dv);
      vec_t r;
      r.en = e; r.cv = c; r.cd = d;
      r.exp_flags = {ck, tk, rn, rd};
      r.exp_div = dv;
      vecs.push_back(r);
   endtask

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic int outs();
      return {20'd0, clkout, tick, running, cfg_ready, div_cur};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // N=4 from reset
      v(0,0,0, 0,0,0,1,4);
      v(1,0,0, 1,0,1,1,4); v(1,0,0, 1,0,1,1,4); v(1,0,0, 0,0,1,1,4); v(1,0,0, 0,1,1,1,4);
      v(1,0,0, 1,0,1,1,4); v(1,0,0, 1,0,1,1,4); v(1,0,0, 0,0,1,1,4); v(1,0,0, 0,1,1,1,4);
      // offer 6 at cnt=1, period of 4 completes, then 6-cycle periods
      v(1,0,0, 1,0,1,1,4); v(1,0,0, 1,0,1,1,4);
      v(1,1,6, 0,0,1,0,4); v(1,0,0, 0,1,1,0,4);
      v(1,0,0, 1,0,1,1,6); v(1,0,0, 1,0,1,1,6); v(1,0,0, 1,0,1,1,6);
      v(1,0,0, 0,0,1,1,6); v(1,0,0, 0,0,1,1,6); v(1,0,0, 0,1,1,1,6);
      // switch to N=5 offered at cnt=0
      v(1,0,0, 1,0,1,1,6); v(1,1,5, 1,0,1,0,6); v(1,0,0, 1,0,1,0,6);
      v(1,0,0, 0,0,1,0,6); v(1,0,0, 0,0,1,0,6); v(1,0,0, 0,1,1,0,6);
      v(1,0,0, 1,0,1,1,5); v(1,0,0, 1,0,1,1,5); v(1,0,0, 1,0,1,1,5);
      // en low at cnt=2: drain cnt 3,4 then idle
      v(0,0,0, 0,0,1,0,5); v(0,0,0, 0,1,1,0,5); v(0,0,0, 0,0,0,1,5); v(0,0,0, 0,0,0,1,5);
      // drain interrupted by en: no gap
      v(1,0,0, 1,0,1,1,5); v(1,0,0, 1,0,1,1,5); v(1,0,0, 1,0,1,1,5);
      v(0,0,0, 0,0,1,0,5); v(1,0,0, 0,1,1,1,5); v(1,0,0, 1,0,1,1,5);
      v(0,0,0, 1,0,1,0,5); v(0,0,0, 1,0,1,0,5); v(0,0,0, 0,0,1,0,5);
      v(0,0,0, 0,1,1,0,5); v(0,0,0, 0,0,0,1,5);
      // N=3 configured in idle
      v(0,1,3, 0,0,0,1,3);
      v(1,0,0, 1,0,1,1,3); v(1,0,0, 1,0,1,1,3); v(1,0,0, 0,1,1,1,3);
      v(1,0,0, 1,0,1,1,3); v(1,0,0, 1,0,1,1,3); v(1,0,0, 0,1,1,1,3);
      v(0,0,0, 0,0,0,1,3);
      // cfg_div=0 clamps to 1
      v(0,1,0, 0,0,0,1,1);
      v(1,0,0, 1,1,1,1,1); v(1,0,0, 1,1,1,1,1); v(1,0,0, 1,1,1,1,1);
      // transfer in a tick cycle applies at the following period end
      v(1,1,2, 1,1,1,0,1); v(1,0,0, 1,0,1,1,2); v(1,0,0, 0,1,1,1,2); v(1,0,0, 1,0,1,1,2);
      v(0,0,0, 0,1,1,0,2); v(0,0,0, 0,0,0,1,2);
      // transfer and en fall in the same RUN cycle
      v(1,0,0, 1,0,1,1,2); v(0,1,4, 0,1,1,0,2); v(0,0,0, 0,0,0,1,4);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", outs(), {20'd0, 4'b0001, 8'd4});
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
      check("reset_period_cnt", int'(period_cnt), 0);
`endif
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         en = vecs[i].en;
         cfg_valid = vecs[i].cv;
         cfg_div = vecs[i].cd;
         step();
         check($sformatf("vec%0d", i), outs(),
               {20'd0, vecs[i].exp_flags, vecs[i].exp_div});
      end

      // reset while PEND at cnt=2 of N=4 discards the pending ratio
      cfg_valid = 1'b0; en = 1'b1;
      step(); step();                      // cnt0, cnt1
      cfg_valid = 1'b1; cfg_div = 8'd7;
      step();
      cfg_valid = 1'b0;
      check("pend_before_rst", outs(), {20'd0, 4'b0010, 8'd4});
      rst = 1'b1;
      #1;
      check("async_rst", outs(), {20'd0, 4'b0001, 8'd4});
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
      check("rst_period_cnt", int'(period_cnt), 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         step();
         check($sformatf("post_rst_c%0d", c), outs(),
               {20'd0, (c % 4 == 1 || c % 4 == 2), (c % 4 == 0), 2'b11, 8'd4});
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
         check($sformatf("period_cnt_c%0d", c), int'(period_cnt), c / 4);
`endif
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
